noc_traffic_gen: RTL

Synthesizable, clocked, multi-channel packet source for router and mesh benches. It replaces the per-direction behavioural CSP generators with one parametrised block. Each of NUM_PORTS channels emits a bounded packet stream in the router flit format (dir | hop | src | payload) over a valid/ready handshake. Field-update mode, inter-packet gap and packet limit are configurable.

---
 rtl/noc_traffic_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_gen.sv
// Multi-channel NoC packet source: each channel streams PKT_LIMIT flits (dir|hop|src|payload) over valid/ready.
// Optional per-channel stall counters are built when NOC_TRAFFIC_GEN_STATS_EN is defined.
module noc_traffic_gen #(
    parameter int NUM_PORTS  = 5,
    parameter int WIDTH      = 15,
    parameter int HOP_W      = 3,
    parameter int SRC_W      = 3,
    parameter int PKT_LIMIT  = 5,
    parameter int HOP_STEP   = 3,
    parameter int GAP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [NUM_PORTS-1:0]       en_i,
    input  logic [2*NUM_PORTS-1:0]     mode_i,
    output logic [NUM_PORTS*WIDTH-1:0] pkt_o,
    output logic [NUM_PORTS-1:0]       valid_o,
    input  logic [NUM_PORTS-1:0]       ready_i,
    output logic [NUM_PORTS-1:0]       done_o,
    output logic                       all_done_o,
    output logic [16*NUM_PORTS-1:0]    stall_cnt_o
);

    localparam int PL_W  = WIDTH - 2 - HOP_W - SRC_W;
    localparam int CNT_W = $clog2(PKT_LIMIT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Handshake: a flit moves on a clk edge where valid_o[i] && ready_i[i];
    // once valid_o[i] is high, pkt_o for that channel holds until that edge.
    state_e           state_q [NUM_PORTS];
    logic [1:0]       dir_q   [NUM_PORTS];
    logic [HOP_W-1:0] hop_q   [NUM_PORTS];
    logic [PL_W-1:0]  pl_q    [NUM_PORTS];
    logic [CNT_W-1:0] cnt_q   [NUM_PORTS];
    logic [GAP_W-1:0] gap_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0] valid_q;
    logic [NUM_PORTS-1:0] done_q;
    logic [NUM_PORTS-1:0] mask_q;

    logic [1:0]       dir_d   [NUM_PORTS];
    logic [HOP_W-1:0] hop_d   [NUM_PORTS];
    logic [PL_W-1:0]  pl_d    [NUM_PORTS];
    logic [CNT_W-1:0] cnt_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] launch;
    logic [NUM_PORTS-1:0] xfer;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            case (mode_i[2*i +: 2])
                2'd0:    dir_d[i] = dir_q[i] ^ 2'b01;
                2'd2:    dir_d[i] = dir_q[i] + 2'd1;
                default: dir_d[i] = dir_q[i];
            endcase
            hop_d[i]  = hop_q[i] + HOP_W'(HOP_STEP);
            pl_d[i]   = pl_q[i] + PL_W'(1);
            cnt_d[i]  = cnt_q[i] + CNT_W'(1);
            xfer[i]   = valid_q[i] & ready_i[i];
            launch[i] = start_i & en_i[i] &
                        ((state_q[i] == ST_IDLE) | (state_q[i] == ST_DONE));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
                dir_q[i]   <= '0;
                hop_q[i]   <= '0;
                pl_q[i]    <= '0;
                cnt_q[i]   <= '0;
                gap_q[i]   <= '0;
            end
            valid_q <= '0;
            done_q  <= '0;
            mask_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                case (state_q[i])
                    ST_IDLE, ST_DONE: begin
                        // Restart keeps the field values so a new run continues the sequence.
                        if (launch[i]) begin
                            state_q[i] <= ST_SEND;
                            valid_q[i] <= 1'b1;
                            done_q[i]  <= 1'b0;
                            cnt_q[i]   <= '0;
                            mask_q[i]  <= 1'b1;
                        end
                    end
                    ST_SEND: begin
                        if (xfer[i]) begin
                            dir_q[i] <= dir_d[i];
                            hop_q[i] <= hop_d[i];
                            pl_q[i]  <= pl_d[i];
                            cnt_q[i] <= cnt_d[i];
                            if (cnt_d[i] == CNT_W'(PKT_LIMIT)) begin
                                state_q[i] <= ST_DONE;
                                valid_q[i] <= 1'b0;
                                done_q[i]  <= 1'b1;
                            end else if (GAP_CYCLES != 0) begin
                                state_q[i] <= ST_GAP;
                                valid_q[i] <= 1'b0;
                                gap_q[i]   <= GAP_LOAD;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_q[i] == '0) begin
                            state_q[i] <= ST_SEND;
                            valid_q[i] <= 1'b1;
                        end else begin
                            gap_q[i] <= gap_q[i] - GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= ST_IDLE;
                        valid_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef NOC_TRAFFIC_GEN_STATS_EN
    logic [15:0] stall_q [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) stall_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (launch[i]) begin
                    stall_q[i] <= '0;
                end else if (valid_q[i] && !ready_i[i] && (stall_q[i] != 16'hFFFF)) begin
                    stall_q[i] <= stall_q[i] + 16'd1;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
        localparam logic [SRC_W-1:0] SRC_ID = SRC_W'(g);
        assign pkt_o[g*WIDTH +: WIDTH] = valid_q[g] ? {dir_q[g], hop_q[g], SRC_ID, pl_q[g]} : '0;
`ifdef NOC_TRAFFIC_GEN_STATS_EN
        assign stall_cnt_o[g*16 +: 16] = stall_q[g];
`endif
    end

`ifndef NOC_TRAFFIC_GEN_STATS_EN
    assign stall_cnt_o = '0;
`endif

    assign valid_o    = valid_q;
    assign done_o     = done_q;
    // Only channels that were actually launched take part; nothing launched means not done.
    assign all_done_o = (|mask_q) & (&(done_q | ~mask_q));

endmodule
